// File: rtl/sp_ram_req_ctrl.sv
// Request controller in front of a single-port RAM: round-robin write/read arbitration,
// one access per cycle, and a 2-entry credit-guarded response FIFO for read data.
module sp_ram_req_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_DI,
  output logic [DATA_WIDTH-1:0] mem_BW,
  output logic                  mem_CE,
  output logic                  mem_RDWEN,
  input  logic [DATA_WIDTH-1:0] mem_DO
);

  logic                  run_r;
  logic                  inflight_r;
  logic                  prefer_wr_r;
  logic [1:0]            count_r;
  logic                  wptr_r;
  logic                  rptr_r;
  logic [DATA_WIDTH-1:0] fifo_r [2];

  logic       pop_s;
  logic [2:0] occ_s;
  logic       rd_elig_s;
  logic       wr_elig_s;
  logic       wr_fire_s;
  logic       rd_fire_s;

  assign rsp_valid = (count_r != 2'd0);
  assign rsp_data  = fifo_r[rptr_r];

  // Eligibility and arbitration; a side's ready never looks at its own valid.
  always_comb begin
    pop_s     = rsp_valid && rsp_ready;
    occ_s     = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    wr_elig_s = run_r;
    rd_elig_s = run_r && (occ_s < 3'd2);
    rd_ready  = rd_elig_s && (!(wr_valid && wr_elig_s) || !prefer_wr_r);
    wr_ready  = wr_elig_s && (!(rd_valid && rd_elig_s) || prefer_wr_r);
    wr_fire_s = wr_valid && wr_ready;
    rd_fire_s = rd_valid && rd_ready;
  end

  // RAM port mux: idle cycles drive all-zero command fields.
  always_comb begin
    mem_CE    = 1'b0;
    mem_RDWEN = 1'b0;
    mem_A     = {ADDR_WIDTH{1'b0}};
    mem_DI    = {DATA_WIDTH{1'b0}};
    mem_BW    = {DATA_WIDTH{1'b0}};
    if (wr_fire_s) begin
      mem_CE    = 1'b1;
      mem_RDWEN = 1'b1;
      mem_A     = wr_addr;
      mem_DI    = wr_data;
      mem_BW    = wr_mask;
    end else if (rd_fire_s) begin
      mem_CE    = 1'b1;
      mem_A     = rd_addr;
    end else begin
      mem_CE    = 1'b0;
    end
  end

  // Control state: enable flag, read pipeline, arbitration pointer and FIFO bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_r       <= 1'b0;
      inflight_r  <= 1'b0;
      prefer_wr_r <= 1'b0;
      count_r     <= 2'd0;
      wptr_r      <= 1'b0;
      rptr_r      <= 1'b0;
      fifo_r[0]   <= {DATA_WIDTH{1'b0}};
      fifo_r[1]   <= {DATA_WIDTH{1'b0}};
    end else begin
      run_r      <= 1'b1;
      inflight_r <= rd_fire_s;
      if (wr_fire_s) begin
        prefer_wr_r <= 1'b0;
      end else if (rd_fire_s) begin
        prefer_wr_r <= 1'b1;
      end
      // RAM data is valid only in the cycle after the read grant.
      if (inflight_r) begin
        fifo_r[wptr_r] <= mem_DO;
        wptr_r         <= ~wptr_r;
      end
      if (pop_s) begin
        rptr_r <= ~rptr_r;
      end
      count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// Scoreboard bench for sp_ram_req_ctrl: directed writes/reads against a behavioural RAM,
// expected responses queued at read grant and checked by an independent monitor.
module tb_sp_ram_req_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = 8'h00;
  logic [DW-1:0] wr_data = 32'h0;
  logic [DW-1:0] wr_mask = 32'h0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = 8'h00;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_DI;
  logic [DW-1:0] mem_BW;
  logic          mem_CE;
  logic          mem_RDWEN;
  logic [DW-1:0] mem_DO = 32'h0;

  sp_ram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_A(mem_A), .mem_DI(mem_DI), .mem_BW(mem_BW), .mem_CE(mem_CE), .mem_RDWEN(mem_RDWEN),
    .mem_DO(mem_DO)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t          sbq[$];
  bit            grant_log[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [DW-1:0] ram [0:255];
  logic          hold;
  logic [DW-1:0] hold_data;
  logic          wf;
  logic          rf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural single-port RAM with one-cycle read latency and per-bit write mask.
  always @(posedge CLK) begin
    if (mem_CE) begin
      if (mem_RDWEN) ram[mem_A] <= (ram[mem_A] & ~mem_BW) | (mem_DI & mem_BW);
      else mem_DO <= ram[mem_A];
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: access rules every cycle, response scoreboard, hold stability.
  always @(negedge CLK) begin
    if (!RST) begin
      wf = wr_valid && wr_ready;
      rf = rd_valid && rd_ready;
      chk("mem_ce", 32'(mem_CE), 32'(wf || rf));
      chk("one_access", 32'(wf && rf), 32'h0);
      if (!mem_CE)
        chk("mem_idle_zero", 32'((|mem_A) | (|mem_DI) | (|mem_BW) | mem_RDWEN), 32'h0);
      if (wf) grant_log.push_back(1'b1);
      else if (rf) grant_log.push_back(1'b0);
      if (hold) begin
        chk("hold_valid", 32'(rsp_valid), 32'h1);
        chk("hold_data", rsp_data, hold_data);
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_data", rsp_data, e.data);
          if (e.cyc >= 0) chk("rsp_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      hold      = rsp_valid && !rsp_ready;
      hold_data = rsp_data;
    end else begin
      hold = 1'b0;
    end
  end

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [31:0] m);
    bit ok = 0;
    wr_addr = a; wr_data = d; wr_mask = m; wr_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      if (wr_ready) ok = 1;
    end
    if (ok) begin
      chk("wr_ce", 32'(mem_CE), 32'h1);
      chk("wr_rdwen", 32'(mem_RDWEN), 32'h1);
      chk("wr_addr", 32'(mem_A), 32'(a));
      chk("wr_di", mem_DI, d);
      chk("wr_bw", mem_BW, m);
      @(posedge CLK); #1;
    end else begin
      chk("wr_grant_timeout", 32'h0, 32'h1);
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] d, input bit lat, input bit push,
                         output int gcyc);
    bit ok = 0;
    exp_t e;
    gcyc = -1;
    rd_addr = a; rd_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      if (rd_ready) ok = 1;
    end
    if (ok) begin
      gcyc = cyc;
      e.data = d;
      e.cyc  = lat ? cyc + 2 : -1;
      if (push) sbq.push_back(e);
      chk("rd_ce", 32'(mem_CE), 32'h1);
      chk("rd_rdwen", 32'(mem_RDWEN), 32'h0);
      chk("rd_addr", 32'(mem_A), 32'(a));
      chk("rd_bw_di", mem_BW | mem_DI, 32'h0);
      @(posedge CLK); #1;
    end else begin
      chk("rd_grant_timeout", 32'h0, 32'h1);
    end
    rd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'h0);
  endtask

  initial begin
    int g, first, last, nrd;
    exp_t e;
    for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
    hold = 1'b0;

    // Reset state with both requests pending, then alternating arbitration.
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 32'h1111_2222; wr_mask = 32'hFFFF_FFFF;
    rd_valid = 1'b1; rd_addr = 8'h10;
    repeat (2) @(negedge CLK);
    chk("rst_wr_ready", 32'(wr_ready), 32'h0);
    chk("rst_rd_ready", 32'(rd_ready), 32'h0);
    chk("rst_mem_ce", 32'(mem_CE), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    e.data = 32'hC0DE_0010; e.cyc = -1;
    sbq.push_back(e);
    sbq.push_back(e);
    grant_log.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int n = 0; n < 20 && grant_log.size() < 4; n++) begin
      @(posedge CLK); #1;
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk("arb_grants", 32'(grant_log.size()), 32'h4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("arb_order", 32'(grant_log[i]), 32'(i % 2));
    wait_drain();

    // Full write then read back with 2-cycle latency; then partial-mask overwrite.
    do_write(8'h05, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
    do_read(8'h05, 32'hDEAD_BEEF, 1'b1, 1'b1, g);
    wait_drain();
    do_write(8'h05, 32'h1234_5678, 32'h0000_FFFF);
    do_read(8'h05, 32'hDEAD_5678, 1'b1, 1'b1, g);
    wait_drain();

    // Back-pressure: two reads fill the credit, further reads stall, writes proceed.
    rsp_ready = 1'b0;
    grant_log.delete();
    do_read(8'h01, 32'hC0DE_0001, 1'b0, 1'b1, g);
    do_read(8'h02, 32'hC0DE_0002, 1'b0, 1'b1, g);
    rd_addr = 8'h03; rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rd_blocked", 32'(rd_ready), 32'h0);
    end
    @(posedge CLK); #1;
    do_write(8'h30, 32'h5555_AAAA, 32'hFFFF_FFFF);
    nrd = 0;
    foreach (grant_log[i]) if (!grant_log[i]) nrd++;
    chk("bp_read_grants", 32'(nrd), 32'h2);
    rsp_ready = 1'b1;
    do_read(8'h03, 32'hC0DE_0003, 1'b0, 1'b1, g);
    wait_drain();

    // Streaming: eight reads on consecutive cycles.
    first = -1; last = -1;
    for (int i = 0; i < 8; i++) begin
      do_read(8'(i), (i == 5) ? 32'hDEAD_5678 : (32'hC0DE_0000 | 32'(i)), 1'b1, 1'b1, g);
      if (i == 0) first = g;
      last = g;
    end
    chk("stream_span", 32'(last - first), 32'h7);
    wait_drain();

    // Reset while a read is in flight: its data must never surface.
    do_read(8'h06, 32'hC0DE_0006, 1'b0, 1'b0, g);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst_inflight_rsp", 32'(rsp_valid), 32'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("post_rst_rsp", 32'(rsp_valid), 32'h0);
    end
    @(posedge CLK); #1;
    do_read(8'h05, 32'hDEAD_5678, 1'b1, 1'b1, g);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
